// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared definitions for the LEGv8 execute stage: ALU control
//               codes, the R-type opcodes decoded under ALUOp 10, the bit
//               positions of the packed id_ctrl vector, the XZR index helper
//               and the ALU control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_ORR   = 3'd3,
        ALU_PASSB = 3'd4,
        ALU_MUL   = 3'd5
    } alu_ctrl_e;

    localparam logic [10:0] c_opc_add = 11'b10001011000;
    localparam logic [10:0] c_opc_sub = 11'b11001011000;
    localparam logic [10:0] c_opc_and = 11'b10001010000;
    localparam logic [10:0] c_opc_orr = 11'b10101010000;
    localparam logic [10:0] c_opc_mul = 11'b10011011000;

    // Bit positions inside id_ctrl / ex_ctrl.
    typedef enum int unsigned {
        CTRL_MEM_WRITE     = 0,
        CTRL_MEM_TO_REG    = 1,
        CTRL_MEM_READ      = 2,
        CTRL_BRANCH        = 3,
        CTRL_UNCOND_BRANCH = 4,
        CTRL_REG_WRITE     = 5
    } ctrl_bit_e;

    // The all-ones register index is the hard-wired zero register.
    function automatic int unsigned xzr_index(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    function automatic alu_ctrl_e alu_decode(input logic [1:0]  alu_op,
                                             input logic [10:0] opcode);
        alu_ctrl_e v;
        v = ALU_ADD;
        case (alu_op)
            2'b01: v = ALU_PASSB;
            2'b10: begin
                case (opcode)
                    c_opc_sub: v = ALU_SUB;
                    c_opc_and: v = ALU_AND;
                    c_opc_orr: v = ALU_ORR;
                    c_opc_mul: v = ALU_MUL;
                    default:   v = ALU_ADD;
                endcase
            end
            default: v = ALU_ADD;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_if
// Description : Bundle between decode/memory and the execute stage.
//               master : decode side (drives id_*, fwd_*, mem_stall, flush)
//               slave  : ex_stage (drives id_ready and all ex_* results)
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if
    import ex_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int REG_AW = 5,
    parameter int OPC_W  = 11
);
    logic              id_valid;
    logic              id_ready;
    logic              mem_stall;
    logic              flush;
    logic [WORD_W-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [OPC_W-1:0]  id_opcode;
    logic [1:0]        id_alu_op;
    logic              id_alu_src;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_wreg;
    logic [5:0]        id_ctrl;
    logic              fwd_em_we, fwd_mw_we;
    logic [REG_AW-1:0] fwd_em_wreg, fwd_mw_wreg;
    logic [WORD_W-1:0] fwd_em_data, fwd_mw_data;
    logic              ex_valid;
    logic              ex_busy;
    logic [WORD_W-1:0] ex_alu_result, ex_branch_target, ex_rd2, ex_pc;
    logic              ex_zero;
    logic [REG_AW-1:0] ex_wreg;
    logic [5:0]        ex_ctrl;

    modport master (
        output id_valid, mem_stall, flush, id_pc, id_rd1, id_rd2, id_imm,
               id_opcode, id_alu_op, id_alu_src, id_rs1, id_rs2, id_wreg, id_ctrl,
               fwd_em_we, fwd_em_wreg, fwd_em_data, fwd_mw_we, fwd_mw_wreg, fwd_mw_data,
        input  id_ready, ex_valid, ex_busy, ex_alu_result, ex_branch_target,
               ex_rd2, ex_pc, ex_zero, ex_wreg, ex_ctrl
    );

    modport slave (
        input  id_valid, mem_stall, flush, id_pc, id_rd1, id_rd2, id_imm,
               id_opcode, id_alu_op, id_alu_src, id_rs1, id_rs2, id_wreg, id_ctrl,
               fwd_em_we, fwd_em_wreg, fwd_em_data, fwd_mw_we, fwd_mw_wreg, fwd_mw_data,
        output id_ready, ex_valid, ex_busy, ex_alu_result, ex_branch_target,
               ex_rd2, ex_pc, ex_zero, ex_wreg, ex_ctrl
    );
endinterface
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_mul_iter
// Description : Iterative shift-add multiplier retiring MUL_STEP multiplier
//               bits per cycle; returns the low WORD_W bits of i_a * i_b.
//   clk       in  clock
//   i_start   in  latch i_a/i_b and begin (honoured only when idle)
//   i_abort   in  synchronous abort / clear (flush or reset)
//   i_a, i_b  in  operands
//   o_busy    out iterating; drops after the last step
//   o_product out product, stable once o_busy is low
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int WORD_W   = 64,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    output logic              o_busy,
    output logic [WORD_W-1:0] o_product
);
    localparam int c_iter  = WORD_W / MUL_STEP;
    localparam int c_cnt_w = $clog2(c_iter + 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WORD_W-1:0]  r_acc, r_a, r_b;

    always_ff @(posedge clk) begin
        if (i_abort) r_state <= c_st_idle;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (i_start) w_state_nxt = c_st_run;
            c_st_run:  if (r_cnt == '0) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // One partial product per RUN cycle: multiplicand shifted left,
    // multiplier consumed MUL_STEP bits at a time from the bottom.
    always_ff @(posedge clk) begin
        if (i_abort) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (r_state == c_st_idle && i_start) begin
            r_acc <= '0;
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= c_cnt_w'(c_iter - 1);
        end else if (r_state == c_st_run) begin
            r_acc <= r_acc + r_a * WORD_W'(r_b[MUL_STEP-1:0]);
            r_a   <= r_a << MUL_STEP;
            r_b   <= r_b >> MUL_STEP;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy    = (r_state == c_st_run);
    assign o_product = r_acc;
endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : LEGv8 execute stage: valid-tagged ID/EX register, ALU,
//               zero flag, branch target, stall/flush handling and an
//               iterative MUL that back-pressures decode through id_ready.
//   clk    in  clock
//   rst_n  in  synchronous active-low reset
//   bus    slave side of ex_stage_if (id_*, fwd_*, mem_stall, flush in;
//          id_ready and ex_* results out)
// Build option : define EX_FORWARD_EN to take register operands from the
//                EX/MEM and MEM/WB write-back forward paths.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int WORD_W   = 64,
    parameter int REG_AW   = 5,
    parameter int OPC_W    = 11,
    parameter int MUL_STEP = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave bus
);
    logic              r_valid;
    logic [WORD_W-1:0] r_pc, r_rd1, r_rd2, r_imm;
    logic [OPC_W-1:0]  r_opcode;
    logic [1:0]        r_alu_op;
    logic              r_alu_src;
    logic [REG_AW-1:0] r_rs1, r_rs2, r_wreg;
    logic [5:0]        r_ctrl;

    logic              w_busy, w_accept, w_mul_start, w_abort, w_ex_valid;
    logic [WORD_W-1:0] w_op_a, w_op_breg, w_op_b, w_id_a, w_id_breg, w_id_b;
    logic [WORD_W-1:0] w_product, w_result;
    alu_ctrl_e         w_alu_ctrl;

    assign bus.id_ready = !bus.mem_stall && !w_busy;
    // Flush beats a load in the same cycle.
    assign w_accept     = bus.id_ready && !bus.flush;

`ifdef EX_FORWARD_EN
    localparam logic [REG_AW-1:0] c_xzr = REG_AW'(xzr_index(REG_AW));

    function automatic logic [WORD_W-1:0] f_fwd(
        input logic [REG_AW-1:0] rs,      input logic [WORD_W-1:0] regval,
        input logic              em_we,   input logic [REG_AW-1:0] em_wreg,
        input logic [WORD_W-1:0] em_data, input logic              mw_we,
        input logic [REG_AW-1:0] mw_wreg, input logic [WORD_W-1:0] mw_data);
        logic [WORD_W-1:0] v;
        v = regval;
        if (rs != c_xzr) begin
            if (em_we && em_wreg == rs)      v = em_data;
            else if (mw_we && mw_wreg == rs) v = mw_data;
        end
        return v;
    endfunction

    assign w_op_a    = f_fwd(r_rs1, r_rd1, bus.fwd_em_we, bus.fwd_em_wreg, bus.fwd_em_data,
                             bus.fwd_mw_we, bus.fwd_mw_wreg, bus.fwd_mw_data);
    assign w_op_breg = f_fwd(r_rs2, r_rd2, bus.fwd_em_we, bus.fwd_em_wreg, bus.fwd_em_data,
                             bus.fwd_mw_we, bus.fwd_mw_wreg, bus.fwd_mw_data);
    // The multiplier latches its operands as the MUL enters, so it sees the
    // forward network on the decode-side indices.
    assign w_id_a    = f_fwd(bus.id_rs1, bus.id_rd1, bus.fwd_em_we, bus.fwd_em_wreg,
                             bus.fwd_em_data, bus.fwd_mw_we, bus.fwd_mw_wreg, bus.fwd_mw_data);
    assign w_id_breg = f_fwd(bus.id_rs2, bus.id_rd2, bus.fwd_em_we, bus.fwd_em_wreg,
                             bus.fwd_em_data, bus.fwd_mw_we, bus.fwd_mw_wreg, bus.fwd_mw_data);
`else
    assign w_op_a    = r_rd1;
    assign w_op_breg = r_rd2;
    assign w_id_a    = bus.id_rd1;
    assign w_id_breg = bus.id_rd2;

    // Forward ports and source indices exist but have no effect in this build.
    logic w_fwd_unused;
    assign w_fwd_unused = ^{bus.fwd_em_we, bus.fwd_em_wreg, bus.fwd_em_data,
                            bus.fwd_mw_we, bus.fwd_mw_wreg, bus.fwd_mw_data,
                            r_rs1, r_rs2};
`endif

    assign w_id_b      = bus.id_alu_src ? bus.id_imm : w_id_breg;
    assign w_mul_start = w_accept && bus.id_valid &&
                         (alu_decode(bus.id_alu_op, 11'(bus.id_opcode)) == ALU_MUL);
    assign w_abort     = !rst_n || bus.flush;

    ex_mul_iter #(
        .WORD_W   (WORD_W),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk       (clk),
        .i_start   (w_mul_start),
        .i_abort   (w_abort),
        .i_a       (w_id_a),
        .i_b       (w_id_b),
        .o_busy    (w_busy),
        .o_product (w_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
            r_opcode  <= '0;
            r_alu_op  <= '0;
            r_alu_src <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_wreg    <= '0;
            r_ctrl    <= '0;
        end else if (bus.flush) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= bus.id_valid;
            r_pc      <= bus.id_pc;
            r_rd1     <= bus.id_rd1;
            r_rd2     <= bus.id_rd2;
            r_imm     <= bus.id_imm;
            r_opcode  <= bus.id_opcode;
            r_alu_op  <= bus.id_alu_op;
            r_alu_src <= bus.id_alu_src;
            r_rs1     <= bus.id_rs1;
            r_rs2     <= bus.id_rs2;
            r_wreg    <= bus.id_wreg;
            r_ctrl    <= bus.id_ctrl;
        end
    end

    assign w_alu_ctrl = alu_decode(r_alu_op, 11'(r_opcode));
    assign w_op_b     = r_alu_src ? r_imm : w_op_breg;

    always_comb begin
        w_result = w_op_a + w_op_b;
        case (w_alu_ctrl)
            ALU_SUB:   w_result = w_op_a - w_op_b;
            ALU_AND:   w_result = w_op_a & w_op_b;
            ALU_ORR:   w_result = w_op_a | w_op_b;
            ALU_PASSB: w_result = w_op_b;
            ALU_MUL:   w_result = w_product;
            default:   w_result = w_op_a + w_op_b;
        endcase
    end

    // Every result is zeroed while no completed instruction is present, so
    // bubbles, flushed slots and reset all present a quiet bus downstream.
    assign w_ex_valid           = r_valid && !w_busy;
    assign bus.ex_valid         = w_ex_valid;
    assign bus.ex_busy          = w_busy;
    assign bus.ex_alu_result    = w_ex_valid ? w_result : '0;
    assign bus.ex_zero          = w_ex_valid && (w_result == '0);
    assign bus.ex_branch_target = w_ex_valid ? (r_pc + (r_imm << 2)) : '0;
    assign bus.ex_rd2           = w_ex_valid ? w_op_breg : '0;
    assign bus.ex_pc            = w_ex_valid ? r_pc : '0;
    assign bus.ex_wreg          = w_ex_valid ? r_wreg : '0;
    assign bus.ex_ctrl          = w_ex_valid ? r_ctrl : '0;
endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: directed vector table,
//               randomized single-cycle ops against a reference model,
//               multiplier latency/result, stall, flush and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    localparam int W    = 64;
    localparam int AW   = 5;
    localparam int OW   = 11;
    localparam int STEP = 1;
    localparam int ITER = W / STEP;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.WORD_W(W), .REG_AW(AW), .OPC_W(OW)) bus ();

    ex_stage #(.WORD_W(W), .REG_AW(AW), .OPC_W(OW), .MUL_STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc,
                         input logic src, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm, input logic [63:0] pc,
                         input logic [4:0] wreg, input logic [5:0] ctrl);
        bus.id_valid   = v;
        bus.id_alu_op  = op;
        bus.id_opcode  = opc;
        bus.id_alu_src = src;
        bus.id_rd1     = a;
        bus.id_rd2     = b;
        bus.id_imm     = imm;
        bus.id_pc      = pc;
        bus.id_rs1     = 5'd1;
        bus.id_rs2     = 5'd2;
        bus.id_wreg    = wreg;
        bus.id_ctrl    = ctrl;
    endtask

    // Reference: result of one instruction from the ISA rules.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [10:0] opc,
                                          input logic src, input logic [63:0] a,
                                          input logic [63:0] b_reg, input logic [63:0] imm);
        logic [63:0] b;
        b = src ? imm : b_reg;
        if (op == 2'b01) return b;
        if (op == 2'b10) begin
            if (opc == OPC_SUB) return a - b;
            if (opc == OPC_AND) return a & b;
            if (opc == OPC_ORR) return a | b;
            if (opc == OPC_MUL) return a * b;
        end
        return a + b;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [10:0] opc;
        logic        src;
        logic [63:0] a, b, imm, pc;
        logic [63:0] res;
        logic        zero;
        logic [63:0] tgt;
    } vec_t;

    vec_t vecs[11];

    // Issues a MUL, measures edges until ex_valid and checks the product.
    task automatic run_mul(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic stall);
        int lo;
        int k;
        logic [63:0] exp;
        exp = a * b;
        @(negedge clk);
        drive(1'b1, 2'b10, OPC_MUL, 1'b0, a, b, 64'd0, 64'h300, 5'd9, 6'h24);
        tick();
        bus.id_valid = 1'b0;
        if (stall) bus.mem_stall = 1'b1;
        lo = 0;
        k  = 0;
        while (!bus.ex_valid && k < 200) begin
            if (!bus.id_ready) lo++;
            k++;
            tick();
        end
        check({name, " latency"}, 64'(k), 64'(ITER));
        check({name, " ready-low"}, 64'(lo), 64'(ITER));
        check({name, " valid"}, 64'(bus.ex_valid), 64'd1);
        check({name, " product"}, bus.ex_alu_result, exp);
        check({name, " ctrl"}, 64'(bus.ex_ctrl), 64'h24);
        if (stall) begin
            repeat (3) tick();
            check({name, " held valid"}, 64'(bus.ex_valid), 64'd1);
            check({name, " held product"}, bus.ex_alu_result, exp);
            check({name, " held ready"}, 64'(bus.id_ready), 64'd0);
            bus.mem_stall = 1'b0;
            #1;
            check({name, " ready after stall"}, 64'(bus.id_ready), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [10:0] opc;
        logic        src;
        logic [63:0] a, b, imm, pc, exp;
        logic [4:0]  wreg;
        logic [5:0]  ctrl;

        drive(1'b0, 2'b00, 11'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 6'd0);
        bus.mem_stall   = 1'b0;
        bus.flush       = 1'b0;
        bus.fwd_em_we   = 1'b0;
        bus.fwd_em_wreg = '0;
        bus.fwd_em_data = '0;
        bus.fwd_mw_we   = 1'b0;
        bus.fwd_mw_wreg = '0;
        bus.fwd_mw_data = '0;

        vecs[0]  = '{2'b10, OPC_ADD, 1'b0, 64'd5, 64'd7, 64'd1, 64'h40, 64'd12, 1'b0, 64'h44};
        vecs[1]  = '{2'b10, OPC_SUB, 1'b0, 64'd5, 64'd7, 64'd0, 64'h44,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h44};
        vecs[2]  = '{2'b01, OPC_ADD, 1'b0, 64'h55, 64'd0, 64'd3, 64'h100, 64'd0, 1'b1, 64'h10C};
        vecs[3]  = '{2'b10, OPC_AND, 1'b0, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 64'hF000, 1'b0, 64'd0};
        vecs[4]  = '{2'b10, OPC_ORR, 1'b0, 64'hF0F0, 64'h0F0F, 64'd0, 64'd0, 64'hFFFF, 1'b0, 64'd0};
        vecs[5]  = '{2'b00, OPC_SUB, 1'b1, 64'h10, 64'h99, 64'h20, 64'h1000, 64'h30, 1'b0, 64'h1080};
        vecs[6]  = '{2'b10, 11'h7FF, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 64'd3, 1'b0, 64'd0};
        vecs[7]  = '{2'b10, OPC_SUB, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0};
        vecs[8]  = '{2'b00, OPC_ADD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
                     64'd0, 1'b1, 64'd0};
        vecs[9]  = '{2'b01, OPC_ADD, 1'b0, 64'd0, 64'd1, 64'd8, 64'hFFFF_FFFF_FFFF_FFF0,
                     64'd1, 1'b0, 64'h10};
        vecs[10] = '{2'b00, OPC_ADD, 1'b1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h200,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1FC};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", 64'(bus.ex_valid), 64'd0);
        check("reset busy", 64'(bus.ex_busy), 64'd0);
        check("reset result", bus.ex_alu_result, 64'd0);
        check("reset zero", 64'(bus.ex_zero), 64'd0);
        check("reset ctrl", 64'(bus.ex_ctrl), 64'd0);
        check("reset ready", 64'(bus.id_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, issued back to back
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].opc, vecs[i].src, vecs[i].a, vecs[i].b,
                  vecs[i].imm, vecs[i].pc, 5'(i), 6'h20);
            tick();
            check($sformatf("vec%0d valid", i), 64'(bus.ex_valid), 64'd1);
            check($sformatf("vec%0d result", i), bus.ex_alu_result, vecs[i].res);
            check($sformatf("vec%0d zero", i), 64'(bus.ex_zero), 64'(vecs[i].zero));
            check($sformatf("vec%0d target", i), bus.ex_branch_target, vecs[i].tgt);
            check($sformatf("vec%0d rd2", i), bus.ex_rd2, vecs[i].b);
            check($sformatf("vec%0d pc", i), bus.ex_pc, vecs[i].pc);
            check($sformatf("vec%0d wreg", i), 64'(bus.ex_wreg), 64'(i));
            check($sformatf("vec%0d ctrl", i), 64'(bus.ex_ctrl), 64'h20);
        end

        // Bubble insertion
        @(negedge clk);
        drive(1'b0, 2'b10, OPC_ADD, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0, 5'd3, 6'h3F);
        tick();
        check("bubble valid", 64'(bus.ex_valid), 64'd0);
        check("bubble ctrl", 64'(bus.ex_ctrl), 64'd0);

        // Randomized single-cycle ops
        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 4))
                0:       opc = OPC_ADD;
                1:       opc = OPC_SUB;
                2:       opc = OPC_AND;
                3:       opc = OPC_ORR;
                default: opc = 11'($urandom);
            endcase
            if (opc == OPC_MUL) opc = OPC_ADD;
            src  = 1'($urandom);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            imm  = {$urandom, $urandom};
            pc   = {$urandom, $urandom};
            wreg = 5'($urandom);
            ctrl = 6'($urandom);
            if (i % 8 == 0) b = a;
            @(negedge clk);
            drive(1'b1, op, opc, src, a, b, imm, pc, wreg, ctrl);
            tick();
            exp = model(op, opc, src, a, b, imm);
            check($sformatf("rand%0d result", i), bus.ex_alu_result, exp);
            check($sformatf("rand%0d zero", i), 64'(bus.ex_zero), 64'(exp == 64'd0));
            check($sformatf("rand%0d target", i), bus.ex_branch_target, pc + imm * 64'd4);
            check($sformatf("rand%0d ctrl", i), 64'(bus.ex_ctrl), 64'(ctrl));
        end

        // Multiplier: directed, then a following ADD one cycle later
        run_mul("mul 1234x10", 64'h1234, 64'h10, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b10, OPC_ADD, 1'b0, 64'd2, 64'd3, 64'd0, 64'd0, 5'd1, 6'h20);
        tick();
        check("add after mul valid", 64'(bus.ex_valid), 64'd1);
        check("add after mul result", bus.ex_alu_result, 64'd5);
        for (int i = 0; i < 2; i++)
            run_mul($sformatf("mul rand%0d", i), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        run_mul("mul under stall", {$urandom, $urandom}, 64'h1_0000_0003, 1'b1);

        // Flush in cycle 10 of RUN
        @(negedge clk);
        drive(1'b1, 2'b10, OPC_MUL, 1'b0, 64'd77, 64'd3, 64'd0, 64'd0, 5'd2, 6'h20);
        tick();
        bus.id_valid = 1'b0;
        repeat (9) tick();
        check("mid-mul busy", 64'(bus.ex_busy), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.ex_busy), 64'd0);
        check("flush valid", 64'(bus.ex_valid), 64'd0);
        check("flush ctrl", 64'(bus.ex_ctrl), 64'd0);
        check("flush ready", 64'(bus.id_ready), 64'd1);

        // Flush beats a load in the same cycle
        @(negedge clk);
        drive(1'b1, 2'b00, OPC_ADD, 1'b0, 64'd4, 64'd4, 64'd0, 64'd0, 5'd2, 6'h20);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush+load valid", 64'(bus.ex_valid), 64'd0);

        // Flush wins over mem_stall for a held instruction
        @(negedge clk);
        tick();
        check("pre flush+stall valid", 64'(bus.ex_valid), 64'd1);
        bus.mem_stall = 1'b1;
        bus.flush     = 1'b1;
        tick();
        check("flush+stall valid", 64'(bus.ex_valid), 64'd0);
        bus.mem_stall = 1'b0;
        bus.flush     = 1'b0;

        // Forward inputs
        @(negedge clk);
        drive(1'b1, 2'b00, OPC_ADD, 1'b0, 64'h11, 64'd0, 64'd0, 64'd0, 5'd1, 6'h20);
        bus.id_rs1 = 5'd3;
        bus.id_rs2 = 5'd5;
        bus.fwd_em_we = 1'b1; bus.fwd_em_wreg = 5'd3; bus.fwd_em_data = 64'hAA;
        bus.fwd_mw_we = 1'b1; bus.fwd_mw_wreg = 5'd3; bus.fwd_mw_data = 64'hBB;
        tick();
`ifdef EX_FORWARD_EN
        exp = 64'hAA;
`else
        exp = 64'h11;
`endif
        check("fwd em priority", bus.ex_alu_result, exp);
        bus.fwd_em_we = 1'b0;
        #1;
`ifdef EX_FORWARD_EN
        exp = 64'hBB;
`else
        exp = 64'h11;
`endif
        check("fwd mw", bus.ex_alu_result, exp);
        @(negedge clk);
        drive(1'b1, 2'b00, OPC_ADD, 1'b0, 64'h11, 64'd0, 64'd0, 64'd0, 5'd1, 6'h20);
        bus.id_rs1 = 5'd31;
        bus.id_rs2 = 5'd5;
        bus.fwd_em_we = 1'b1; bus.fwd_em_wreg = 5'd31;
        bus.fwd_mw_we = 1'b1; bus.fwd_mw_wreg = 5'd31;
        tick();
        check("fwd xzr", bus.ex_alu_result, 64'h11);
        bus.fwd_em_we = 1'b0;
        bus.fwd_mw_we = 1'b0;

        // Reset while mem_stall holds a valid instruction
        @(negedge clk);
        drive(1'b1, 2'b10, OPC_ADD, 1'b0, 64'd5, 64'd7, 64'd1, 64'h80, 5'd4, 6'h21);
        tick();
        bus.mem_stall = 1'b1;
        drive(1'b1, 2'b10, OPC_SUB, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0, 5'd6, 6'h01);
        tick();
        check("stall hold result", bus.ex_alu_result, 64'd12);
        check("stall hold wreg", 64'(bus.ex_wreg), 64'd4);
        rst_n = 1'b0;
        tick();
        check("rst valid", 64'(bus.ex_valid), 64'd0);
        check("rst result", bus.ex_alu_result, 64'd0);
        check("rst target", bus.ex_branch_target, 64'd0);
        check("rst pc", bus.ex_pc, 64'd0);
        check("rst rd2", bus.ex_rd2, 64'd0);
        check("rst wreg", 64'(bus.ex_wreg), 64'd0);
        check("rst ctrl", 64'(bus.ex_ctrl), 64'd0);
        check("rst zero", 64'(bus.ex_zero), 64'd0);
        check("rst ready stalled", 64'(bus.id_ready), 64'd0);
        rst_n = 1'b1;
        bus.mem_stall = 1'b0;
        #1;
        check("rst ready released", 64'(bus.id_ready), 64'd1);

        // Reset mid-MUL aborts it
        @(negedge clk);
        drive(1'b1, 2'b10, OPC_MUL, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0, 5'd2, 6'h20);
        tick();
        bus.id_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst mid-mul busy", 64'(bus.ex_busy), 64'd0);
        check("rst mid-mul valid", 64'(bus.ex_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
